// File: rtl/cpu_pkg.sv
// Shared constants, control-strobe bundle and opcodes for the 8-bit CPU datapath and decoder.
package cpu_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic io;
    logic ii;
    logic ai;
    logic ao;
    logic sumo;
    logic sub;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
  } ctrl_t;
endpackage

// File: rtl/cpu_datapath_ram16x8.sv
// 16x8 RAM: asynchronous read at MAR, synchronous write muxed between the program port and ri.
// Reset blocks writes but leaves the contents intact.
module ram16x8
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              ri_en,
  input  logic [ADDR_W-1:0] mar,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = mar;
    wr_data = bus_in;
    if (rst) begin
      wr_en = 1'b0;
    end else if (prog_mode) begin
      wr_en   = prog_we;
      wr_addr = prog_addr;
      wr_data = prog_data;
    end else begin
      wr_en = ri_en;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[mar];
endmodule

// File: rtl/cpu_datapath.sv
// Bus/register datapath of the 8-bit CPU: shared bus, PC, MAR, RAM, IR, A/B, adder/subtractor, OUT.
// Optional CPU_FLAGS_EN adds registered carry/zero flags captured on run-enabled sumo cycles.
module cpu_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  input  logic              mi,
  input  logic              ri,
  input  logic              ro,
  input  logic              io,
  input  logic              ii,
  input  logic              ai,
  input  logic              ao,
  input  logic              sumo,
  input  logic              sub,
  input  logic              bi,
  input  logic              oi,
  input  logic              ce,
  input  logic              co,
  input  logic              j,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] insn,
  output logic [DATA_W-1:0] bus,
  output logic              bus_err,
  output logic [DATA_W-1:0] out_val,
  output logic              out_valid,
  output logic              halted,
  output logic              cf,
  output logic              zf
);
  import cpu_pkg::*;

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  ctrl_t             c;
  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic              out_valid_q, out_valid_d, halted_q, halted_d;
  logic [DATA_W-1:0] ram_rd;
  logic [DATA_W:0]   alu_sum;
  logic [4:0]        drv;
  logic              run_en;

  assign c = {hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j};

  // prog_mode and a live hlt both freeze every control-driven load.
  assign run_en  = !prog_mode && !halted_q && !c.hlt;
  assign alu_sum = {1'b0, a_q} + {1'b0, (c.sub ? ~b_q : b_q)} + {{DATA_W{1'b0}}, c.sub};

  always_comb begin
    bus = '0;
    if (c.ro)   bus |= ram_rd;
    if (c.io)   bus |= {{(DATA_W-4){1'b0}}, ir_q[3:0]};
    if (c.ao)   bus |= a_q;
    if (c.sumo) bus |= alu_sum[DATA_W-1:0];
    if (c.co)   bus |= {{(DATA_W-ADDR_W){1'b0}}, pc_q};
  end

  assign drv     = {c.ro, c.io, c.ao, c.sumo, c.co};
  assign bus_err = (drv & (drv - 5'd1)) != 5'd0;

  ram16x8 u_ram (
    .clk       (clk),
    .rst       (rst),
    .prog_mode (prog_mode),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .ri_en     (run_en && c.ri),
    .mar       (mar_q),
    .bus_in    (bus),
    .rd_data   (ram_rd)
  );

  always_comb begin
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    halted_d    = halted_q;
    if (rst) begin
      pc_d     = '0;
      mar_d    = '0;
      ir_d     = '0;
      a_d      = '0;
      b_d      = '0;
      out_d    = '0;
      halted_d = 1'b0;
    end else begin
      if (!prog_mode && c.hlt) halted_d = 1'b1;
      if (run_en) begin
        if (c.mi) mar_d = bus[ADDR_W-1:0];
        if (c.ii) ir_d  = bus;
        if (c.ai) a_d   = bus;
        if (c.bi) b_d   = bus;
        if (c.oi) out_d = bus;
        if (c.j)       pc_d = bus[ADDR_W-1:0];
        else if (c.ce) pc_d = pc_q + PC_ONE;
        out_valid_d = c.oi;
      end
    end
  end

  always_ff @(posedge clk) begin
    pc_q        <= pc_d;
    mar_q       <= mar_d;
    ir_q        <= ir_d;
    a_q         <= a_d;
    b_q         <= b_d;
    out_q       <= out_d;
    out_valid_q <= out_valid_d;
    halted_q    <= halted_d;
  end

  assign insn      = ir_q;
  assign out_val   = out_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;

`ifdef CPU_FLAGS_EN
  logic cf_q, cf_d, zf_q, zf_d;

  always_comb begin
    cf_d = cf_q;
    zf_d = zf_q;
    if (rst) begin
      cf_d = 1'b0;
      zf_d = 1'b0;
    end else if (run_en && c.sumo) begin
      cf_d = alu_sum[DATA_W];
      zf_d = (alu_sum[DATA_W-1:0] == '0);
    end
  end

  always_ff @(posedge clk) begin
    cf_q <= cf_d;
    zf_q <= zf_d;
  end

  assign cf = cf_q;
  assign zf = zf_q;
`else
  logic unused_carry;
  assign unused_carry = alu_sum[DATA_W];
  assign cf = 1'b0;
  assign zf = 1'b0;
`endif
endmodule
